// File: rtl/vram_pkg.sv
// Shared constants and types for the 200x150 8bpp framebuffer writer.
// Opcodes, write modes and FSM states live here so other framebuffer clients can reuse them.
package vram_pkg;

  localparam int H_PIXELS = 200;
  localparam int V_PIXELS = 150;
  localparam int FB_SIZE  = H_PIXELS * V_PIXELS;
  localparam int ADDR_W   = 15;

  localparam logic [1:0] OP_PLOT  = 2'b00;
  localparam logic [1:0] OP_FILL  = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  typedef enum logic {
    IDLE,
    WRITE
  } state_t;

  typedef enum logic {
    MODE_RECT,
    MODE_CLEAR
  } mode_t;

  // Clip a requested extent against the pixels remaining to the edge.
  function automatic logic [8:0] clip9(input logic [8:0] size, input logic [8:0] room);
    return (size < room) ? size : room;
  endfunction

endpackage

// File: rtl/vram_writer_if.sv
// Command handshake plus VRAM write port of the framebuffer writer.
// The master issues drawing commands; the slave is the write engine.
interface vram_writer_if;
  import vram_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [7:0]        cmd_x;
  logic [7:0]        cmd_y;
  logic [7:0]        cmd_w;
  logic [7:0]        cmd_h;
  logic [7:0]        cmd_color;
  logic [ADDR_W-1:0] address;
  logic [7:0]        data;
  logic              we;
  logic              busy;
  logic              err;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, address, data, we, busy, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, address, data, we, busy, err
  );

endinterface

// File: rtl/vram_addr_calc.sv
// Linear framebuffer address y*200 + x built from shifts and adds only.
// Valid for in-range coordinates; the result then never exceeds 29999.
module vram_addr_calc
  import vram_pkg::*;
(
  input  logic [7:0]        x,
  input  logic [7:0]        y,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] y_ext;
  logic [ADDR_W-1:0] x_ext;

  assign y_ext = {7'd0, y};
  assign x_ext = {7'd0, x};

  // 200 = 128 + 64 + 8
  assign addr = (y_ext << 7) + (y_ext << 6) + (y_ext << 3) + x_ext;

endmodule

// File: rtl/vram_writer.sv
// Command-driven VRAM write engine: PLOT, clipped FILL and CLEAR, one pixel per clock.
// All write-port outputs are registered; the first write appears the cycle after acceptance.
module vram_writer
  import vram_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  vram_writer_if.slave bus
);

  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(H_PIXELS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

  state_t            state_reg;
  mode_t             mode_reg;
  logic [ADDR_W-1:0] row_base_reg;
  logic [ADDR_W-1:0] address_reg;
  logic [7:0]        col_reg;
  logic [7:0]        row_reg;
  logic [7:0]        last_col_reg;
  logic [7:0]        last_row_reg;
  logic [7:0]        data_reg;
  logic              we_reg;
  logic              err_reg;

  logic              accept;
  logic              out_of_range;
  logic              reject;
  logic              empty;
  logic [8:0]        x9;
  logic [8:0]        y9;
  logic [8:0]        w9;
  logic [8:0]        h9;
  logic [8:0]        ew9;
  logic [8:0]        eh9;
  logic [ADDR_W-1:0] start_addr;
  logic              last_col;
  logic              last_pixel;
  logic              clear_done;

  vram_addr_calc u_addr_calc (
    .x    (bus.cmd_x),
    .y    (bus.cmd_y),
    .addr (start_addr)
  );

  assign accept = bus.cmd_valid && (state_reg == IDLE);

  // PLOT is a 1x1 FILL; the remaining room is only meaningful for in-range x/y.
  assign x9  = {1'b0, bus.cmd_x};
  assign y9  = {1'b0, bus.cmd_y};
  assign w9  = (bus.cmd_op == OP_PLOT) ? 9'd1 : {1'b0, bus.cmd_w};
  assign h9  = (bus.cmd_op == OP_PLOT) ? 9'd1 : {1'b0, bus.cmd_h};
  assign ew9 = clip9(w9, 9'(H_PIXELS) - x9);
  assign eh9 = clip9(h9, 9'(V_PIXELS) - y9);

  assign out_of_range = (x9 >= 9'(H_PIXELS)) || (y9 >= 9'(V_PIXELS));
  assign reject       = (bus.cmd_op == OP_RSVD) ||
                        ((bus.cmd_op != OP_CLEAR) && out_of_range);
  assign empty        = (ew9 == 9'd0) || (eh9 == 9'd0);

  assign last_col   = (col_reg == last_col_reg);
  assign last_pixel = last_col && (row_reg == last_row_reg);
  assign clear_done = (address_reg == LAST_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_RECT;
      row_base_reg <= '0;
      address_reg  <= '0;
      col_reg      <= '0;
      row_reg      <= '0;
      last_col_reg <= '0;
      last_row_reg <= '0;
      data_reg     <= '0;
      we_reg       <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          we_reg <= 1'b0;
          if (accept) begin
            if (reject) begin
              err_reg <= 1'b1;
            end else if (bus.cmd_op == OP_CLEAR) begin
              mode_reg    <= MODE_CLEAR;
              address_reg <= '0;
              data_reg    <= bus.cmd_color;
              we_reg      <= 1'b1;
              state_reg   <= WRITE;
            end else if (!empty) begin
              mode_reg     <= MODE_RECT;
              row_base_reg <= start_addr;
              address_reg  <= start_addr;
              col_reg      <= '0;
              row_reg      <= '0;
              last_col_reg <= ew9[7:0] - 8'd1;
              last_row_reg <= eh9[7:0] - 8'd1;
              data_reg     <= bus.cmd_color;
              we_reg       <= 1'b1;
              state_reg    <= WRITE;
            end
          end
        end
        WRITE: begin
          if (mode_reg == MODE_CLEAR) begin
            if (clear_done) begin
              we_reg    <= 1'b0;
              state_reg <= IDLE;
            end else begin
              address_reg <= address_reg + 1'b1;
            end
          end else if (last_pixel) begin
            we_reg    <= 1'b0;
            state_reg <= IDLE;
          end else if (last_col) begin
            col_reg      <= '0;
            row_reg      <= row_reg + 8'd1;
            row_base_reg <= row_base_reg + ROW_STEP;
            address_reg  <= row_base_reg + ROW_STEP;
          end else begin
            // Within a row, row_base + col + 1 is simply the next address.
            col_reg     <= col_reg + 8'd1;
            address_reg <= address_reg + 1'b1;
          end
        end
        default: begin
          we_reg    <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.address   = address_reg;
  assign bus.data      = data_reg;
  assign bus.we        = we_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer: command table plus reset-abort sequence,
// with a write scoreboard fed by a reference pixel model.
module tb_vram_writer;

  logic clk;
  logic rst;

  vram_writer_if bus ();

  vram_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] w;
    logic [7:0] h;
    logic [7:0] color;
    logic       exp_err;
    int         exp_n;
  } vec_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  localparam int NVEC = 13;

  vec_t vecs [NVEC];
  wr_t  exp_q [$];
  int   vectors;
  int   miscompares;
  int   wr_cnt;
  logic err_allowed;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: expected write stream of one command, pushed at drive time.
  task automatic model(input logic [1:0] op, input int x, input int y,
                       input int w, input int h, input int color);
    int ww, hh, ew, eh;
    wr_t e;
    if (op == 2'b11) return;
    if (op == 2'b10) begin
      for (int a = 0; a < 30000; a++) begin
        e.addr = a; e.data = color; exp_q.push_back(e);
      end
      return;
    end
    if (x >= 200 || y >= 150) return;
    ww = (op == 2'b00) ? 1 : w;
    hh = (op == 2'b00) ? 1 : h;
    ew = (ww < 200 - x) ? ww : 200 - x;
    eh = (hh < 150 - y) ? hh : 150 - y;
    for (int r = 0; r < eh; r++)
      for (int c = 0; c < ew; c++) begin
        e.addr = (y + r) * 200 + (x + c); e.data = color; exp_q.push_back(e);
      end
  endtask

  task automatic drive(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                       input logic [7:0] w, input logic [7:0] h, input logic [7:0] color);
    bus.cmd_op = op; bus.cmd_x = x; bus.cmd_y = y;
    bus.cmd_w = w; bus.cmd_h = h; bus.cmd_color = color;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble fields while busy to prove they were latched at acceptance.
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom); bus.cmd_x = 8'($urandom); bus.cmd_y = 8'($urandom);
    bus.cmd_w = 8'($urandom); bus.cmd_h = 8'($urandom); bus.cmd_color = 8'($urandom);
  endtask

  // Called at negedge+1 with the engine idle.
  task automatic issue(input vec_t v, input int idx);
    int w0, cnt, exp_cycles;
    check($sformatf("v%0d_ready_before", idx), bus.cmd_ready, 1);
    model(v.op, v.x, v.y, v.w, v.h, v.color);
    w0 = wr_cnt;
    err_allowed = v.exp_err;
    drive(v.op, v.x, v.y, v.w, v.h, v.color);
    @(negedge clk);
    #1;
    check($sformatf("v%0d_err", idx), bus.err, v.exp_err);
    err_allowed = 1'b0;
    cnt = 1;
    while (!bus.cmd_ready && cnt < 40000) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    exp_cycles = (v.exp_n == 0) ? 1 : v.exp_n + 1;
    check($sformatf("v%0d_cycles_to_ready", idx), cnt, exp_cycles);
    check($sformatf("v%0d_write_count", idx), wr_cnt - w0, v.exp_n);
    check($sformatf("v%0d_pending_writes", idx), exp_q.size(), 0);
    check($sformatf("v%0d_busy_idle", idx), bus.busy, 0);
    exp_q.delete();
  endtask

  initial begin
    vec_t v;
    wr_t e;
    int w0, cnt;

    vectors = 0; miscompares = 0; wr_cnt = 0; err_allowed = 1'b0;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_x = '0; bus.cmd_y = '0;
    bus.cmd_w = '0; bus.cmd_h = '0; bus.cmd_color = '0;

    //            op     x       y       w       h      color  err  n
    vecs[0]  = '{2'b00, 8'd5,   8'd2,   8'd0,   8'd0,   8'h92, 1'b0, 1};
    vecs[1]  = '{2'b01, 8'd198, 8'd148, 8'd4,   8'd5,   8'hFF, 1'b0, 4};
    vecs[2]  = '{2'b00, 8'd200, 8'd0,   8'd1,   8'd1,   8'h11, 1'b1, 0};
    vecs[3]  = '{2'b11, 8'd3,   8'd3,   8'd2,   8'd2,   8'h22, 1'b1, 0};
    vecs[4]  = '{2'b01, 8'd10,  8'd10,  8'd0,   8'd10,  8'h33, 1'b0, 0};
    vecs[5]  = '{2'b00, 8'd0,   8'd150, 8'd1,   8'd1,   8'h44, 1'b1, 0};
    vecs[6]  = '{2'b01, 8'd10,  8'd20,  8'd3,   8'd2,   8'hA5, 1'b0, 6};
    vecs[7]  = '{2'b00, 8'd199, 8'd149, 8'd7,   8'd9,   8'h5A, 1'b0, 1};
    vecs[8]  = '{2'b01, 8'd190, 8'd0,   8'd20,  8'd1,   8'h0F, 1'b0, 10};
    vecs[9]  = '{2'b01, 8'd0,   8'd140, 8'd1,   8'd255, 8'h81, 1'b0, 10};
    vecs[10] = '{2'b01, 8'd5,   8'd5,   8'd4,   8'd0,   8'h66, 1'b0, 0};
    vecs[11] = '{2'b01, 8'd255, 8'd0,   8'd1,   8'd1,   8'h77, 1'b1, 0};
    vecs[12] = '{2'b10, 8'd250, 8'd200, 8'd9,   8'd9,   8'h00, 1'b0, 30000};

    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          if (bus.we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
              check("unexpected_write_addr", bus.address, 32'hFFFF_FFFF);
            end else begin
              e = exp_q.pop_front();
              check("write_addr", bus.address, e.addr);
              check("write_data", bus.data, e.data);
            end
          end
          if (bus.err && !err_allowed) check("stray_err", bus.err, 0);
        end
      end
    join_none

    repeat (2) @(negedge clk);
    #1;
    check("rst_we", bus.we, 0);
    check("rst_address", bus.address, 0);
    check("rst_data", bus.data, 0);
    check("rst_err", bus.err, 0);
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) issue(vecs[i], i);

    // FILL 10x10 at origin, aborted by reset after its 37th write.
    check("abort_ready_before", bus.cmd_ready, 1);
    for (int k = 0; k < 37; k++) begin
      e.addr = (k / 10) * 200 + (k % 10); e.data = 8'hC3; exp_q.push_back(e);
    end
    w0 = wr_cnt;
    drive(2'b01, 8'd0, 8'd0, 8'd10, 8'd10, 8'hC3);
    cnt = 0;
    while ((wr_cnt - w0) < 37 && cnt < 200) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("abort_writes_before_rst", wr_cnt - w0, 37);
    rst = 1'b1;
    #1;
    check("abort_we_async", bus.we, 0);
    check("abort_address_async", bus.address, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("abort_cmd_ready", bus.cmd_ready, 1);
    check("abort_busy", bus.busy, 0);
    @(negedge clk);
    #1;
    check("abort_no_more_writes", wr_cnt - w0, 37);
    check("abort_pending", exp_q.size(), 0);
    exp_q.delete();

    v = '{2'b00, 8'd0, 8'd0, 8'd3, 8'd3, 8'h7E, 1'b0, 1};
    issue(v, 99);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vram_writer.md
# vram_writer

Command-driven write engine for the 200×150, 8-bit-per-pixel video RAM that the VGA scan-out reads. It accepts one drawing command at a time from the CPU/bus side: plot a pixel, fill a clipped rectangle, or clear the screen. It then issues one VRAM write per clock on a 15-bit address / 8-bit data write port. It is the writer on the opposite port of the shared dual-port framebuffer. Pixel byte layout is unchanged: bit 7 red, bit 4 green, bit 1 blue.

## Interface
- H_PIXELS, 200, framebuffer width in pixels
- V_PIXELS, 150, framebuffer height in pixels
- ADDR_W, 15, VRAM address width
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle, command accepted on `cmd_valid && cmd_ready` at rising `clk`
- cmd_op  in  2  opcodes: 00 PLOT, 01 FILL, 10 CLEAR, 11 reserved
- cmd_x, cmd_y  in  8 each  top-left pixel coordinate
- cmd_w, cmd_h  in  8 each  FILL size in pixels; ignored by PLOT and CLEAR
- cmd_color  in  8  pixel value written
- address  out  ADDR_W  VRAM write address
- data  out  8  VRAM write data
- we  out  1  VRAM write enable, one pixel per high cycle
- busy  out  1  equals `!cmd_ready`
- err  out  1  one-cycle pulse for a rejected command

## Operation
- FSM states: IDLE, WRITE.
- `cmd_ready` = (state == IDLE).
- Address of pixel (x,y) is y*200 + x, computed as (y<<7)+(y<<6)+(y<<3)+x with no multiplier. The maximum address is 29999.
- Clipping uses 9-bit arithmetic:
  - ew = min(w, 200−x)
  - eh = min(h, 150−y)
- PLOT behaves as FILL with w=h=1.
- Reject cases (x≥200, or y≥150 for PLOT/FILL, or op 11):
  - no writes
  - `err`=1 for the single cycle after the accept edge
  - state stays IDLE
- FILL with ew=0 or eh=0 (w=0 or h=0): no writes, no `err`, state stays IDLE.
- FILL write order is row-major.
  - row_base starts at y*200+x and the column counter at 0.
  - Each write cycle emits address = row_base+col and data = latched color.
  - At col=ew−1: col←0, row_base←row_base+200, row←row+1.
  - After the write at (ew−1, eh−1) the state returns to IDLE.
- CLEAR ignores x/y/w/h and writes cmd_color to addresses 0..29999 in ascending order (30000 writes), then returns to IDLE.
- Command fields are latched at acceptance. Input changes while busy have no effect.

## Timing
- Reset values: we=0, address=0, data=0, err=0, state IDLE (so cmd_ready=1, busy=0). Reset is asynchronous.
- Asserting rst mid-command aborts it immediately. No further writes occur and the remaining pixels are left unwritten.
- address, data, we and err are registered.
- The first write is presented in the cycle immediately after the accept edge.
- A command of N writes holds we=1 for exactly N consecutive cycles with no gaps.
- cmd_ready returns to 1 in the cycle after the last write. The next command can be accepted on that cycle's closing edge.
- PLOT throughput is therefore one command per 2 cycles. A FILL takes ew*eh+1 cycles from accept to the next possible accept.
- A rejected or zero-size command keeps cmd_ready=1, so back-to-back acceptance is allowed.
- Widths:
  - row_base and address: 15 bits
  - column counter and row counter: 8 bits
  - CLEAR counter: 15 bits, terminal at 29999 (no wrap past it)

## Structure
- Shared package `vram_pkg`:
  - H_PIXELS, V_PIXELS, FB_SIZE=30000
  - opcode constants OP_PLOT/OP_FILL/OP_CLEAR/OP_RSVD
  - state enum {IDLE, WRITE}
  - write-mode enum {MODE_RECT, MODE_CLEAR}
- One sub-module: `vram_addr_calc`, combinational shift-add producing y*200+x (15-bit). It is reusable by other framebuffer clients.

## Test plan
- Reset, then PLOT x=5 y=2 color 0x92 → exactly one `we` cycle with address=405, data=0x92, starting the cycle after accept; cmd_ready=0 for 1 cycle.
- FILL x=198 y=148 w=4 h=5 color 0xFF → clipped to 2×2. Writes in order to 29798, 29799, 29998, 29999; we high 4 consecutive cycles; no `err`.
- PLOT x=200 y=0, then op 11 → no `we`; err pulses 1 cycle after each accept; cmd_ready stays 1.
- FILL w=0 h=10 → no writes, no `err`, next command accepted the following cycle.
- CLEAR color 0x00 → 30000 consecutive writes, address 0 to 29999 ascending. cmd_ready returns 1 exactly 30001 cycles after the accept edge.
- FILL 10×10 at (0,0), assert rst after the 37th write → we=0 asynchronously; after release cmd_ready=1. A new PLOT x=0 y=0 then writes address 0.
